logic_unit_arbiter: RTL and testbench

- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR/NOT) among NREQ requesters in the RISC datapath.
- Requesters are, for example, the main ALU issue slot and the address/mask helper path.
- Arbitration is round-robin with valid/ready handshakes on each request port.
- One registered result slot, tagged with the requester ID, drives a valid/ready response port.

---
 rtl/logic_unit_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Lets NREQ requesters share one bitwise logic unit (AND/OR/XOR/NOR/NOT).
// A round-robin arbiter picks one valid requester per cycle. Its operation is
// evaluated combinationally and captured in a single registered result slot.
// The slot carries the requester ID and drives a valid/ready response port.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NREQ]        requester i presents an operation
//   req_ready  out  [NREQ]        requester i's operation is accepted this cycle
//   req_op     in   [3*NREQ]      opcode of requester i at [3i+2:3i]
//   req_a      in   [WIDTH*NREQ]  operand A of requester i (slice i)
//   req_b      in   [WIDTH*NREQ]  operand B of requester i (slice i)
//   rsp_valid  out  result slot is occupied
//   rsp_ready  in   consumer takes the result
//   rsp_id     out  [ID_W]        index of the requester that produced it
//   rsp_data   out  [WIDTH]       result value
//   rsp_err    out  opcode was illegal (rsp_data is 0 in that case)
//
// Opcodes: 000 A&B, 001 A|B, 010 A^B, 011 ~(A|B), 100 ~A, 101..111 illegal.
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err
);

  // ---------------------------------------------------------------------------
  // Per-requester views of the flattened request buses
  // ---------------------------------------------------------------------------
  logic [2:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[3*gi +: 3];
    assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
    assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic             rsp_err_q,   rsp_err_d;
  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // Scan rr_ptr, rr_ptr+1, ... modulo NREQ. The loop runs from the farthest
  // offset down to offset 0, so the last hit (closest to rr_ptr) wins.
  // scan_sum is one bit wider than ID_W so rr_ptr+k cannot overflow before
  // the modulo fold; NREQ need not be a power of two.
  // ---------------------------------------------------------------------------
  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NREQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NREQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // The slot can take a new result when it is empty or being drained this
  // cycle. Ready is also held low while reset is asserted.
  // ---------------------------------------------------------------------------
  logic slot_free;
  logic accept;

  assign slot_free = !rsp_valid_q || rsp_ready;
  assign accept    = grant_valid && slot_free && !rst;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // Shared logic unit, fed by the granted requester
  // ---------------------------------------------------------------------------
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] lu_result;
  logic             lu_err;

  assign sel_op = op_arr[grant_idx];
  assign sel_a  = a_arr[grant_idx];
  assign sel_b  = b_arr[grant_idx];

  always_comb begin
    lu_result = '0;
    lu_err    = 1'b0;
    case (sel_op)
      3'b000:  lu_result = sel_a & sel_b;
      3'b001:  lu_result = sel_a | sel_b;
      3'b010:  lu_result = sel_a ^ sel_b;
      3'b011:  lu_result = ~(sel_a | sel_b);
      3'b100:  lu_result = ~sel_a;
      default: lu_err    = 1'b1;   // illegal opcode: result stays 0
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // An accept always refills the slot, even when it is drained in the same
  // cycle. A drain without an accept clears only the valid flag; the payload
  // keeps its last value.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_data_d  = lu_result;
      rsp_err_d   = lu_err;
      rr_ptr_d    = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// The stimulus process drives one cycle at a time. For each cycle it asks a
// behavioural model for two things: which requester should be granted, and
// what result that requester should produce. Every expected result is pushed
// into a scoreboard queue.
//
// A separate monitor runs on the falling edge. It compares the slot contents
// against the head of the queue and pops the head on each response handshake.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int ID_W  = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Per-requester stimulus operands, packed onto the buses by step()
  logic [2:0]       op_s [NREQ];
  logic [WIDTH-1:0] a_s  [NREQ];
  logic [WIDTH-1:0] b_s  [NREQ];

  // Model state: slot occupancy and round-robin start point
  logic            m_valid, n_valid;
  int              m_ptr, n_ptr;
  logic            exp_valid;
  logic [NREQ-1:0] exp_ready;
  logic            started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result of one operation straight from the opcode table; bit 32 is the error flag
  function automatic logic [WIDTH:0] ref_op(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~(a | b)};
      3'd4:    return {1'b0, ~a};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  // One clock cycle of stimulus plus the model's prediction for it
  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    int g;
    logic slot_free;
    logic [WIDTH:0] r;
    exp_t e;
    @(posedge clk);
    #1;
    m_valid = n_valid;
    m_ptr   = n_ptr;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]       = op_s[i];
      req_a[WIDTH*i +: WIDTH] = a_s[i];
      req_b[WIDTH*i +: WIDTH] = b_s[i];
    end
    slot_free = !m_valid || rr;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    exp_valid = m_valid;
    exp_ready = '0;
    n_valid   = m_valid;
    n_ptr     = m_ptr;
    if (g >= 0 && slot_free) begin
      exp_ready[g] = 1'b1;
      r = ref_op(op_s[g], a_s[g], b_s[g]);
      e.id   = ID_W'(g);
      e.data = r[WIDTH-1:0];
      e.err  = r[WIDTH];
      sb_q.push_back(e);
      n_valid = 1'b1;
      n_ptr   = (g + 1) % NREQ;
    end else if (m_valid && rr) begin
      n_valid = 1'b0;
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_s[i] = 3'($urandom_range(0, 7));
      a_s[i]  = $urandom;
      b_s[i]  = $urandom;
    end
  endtask

  // Reset asserted between edges. The slot must empty at once, and ready
  // must stay low for as long as reset is held.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_ready", req_ready, '0);
    chk("midrst_data",  rsp_data,  '0);
    chk("midrst_id",    rsp_id,    '0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    sb_q.delete();
    n_valid   = 1'b0;
    n_ptr     = 0;
    exp_valid = 1'b0;
    exp_ready = '0;
  endtask

  // Monitor: response port versus scoreboard head
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("mon_valid", rsp_valid, exp_valid);
      chk("mon_ready", req_ready, exp_ready);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk("mon_unexpected_rsp", 1'b1, 1'b0);
        end else begin
          chk("mon_id",   rsp_id,   sb_q[0].id);
          chk("mon_data", rsp_data, sb_q[0].data);
          chk("mon_err",  rsp_err,  sb_q[0].err);
          if (rsp_ready) begin
            $display("rsp id=%0d data=0x%08h err=%0b", rsp_id, rsp_data, rsp_err);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  logic [2:0]       cov_op   [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
  logic [WIDTH-1:0] cov_data [5] = '{32'hAFAF_F5F5, 32'hA5A5_A5A5, 32'h5050_0A0A,
                                     32'h5555_AAAA, 32'h0000_0000};
  logic             cov_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_s[i] = '0;
      a_s[i]  = '0;
      b_s[i]  = '0;
    end
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    exp_valid = 1'b0;
    exp_ready = '0;
    n_valid   = 1'b0;
    n_ptr     = 0;
    m_valid   = 1'b0;
    m_ptr     = 0;

    // Power-on reset, with requesters already valid
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_id",    rsp_id,    '0);
    chk("rst_data",  rsp_data,  '0);
    chk("rst_err",   rsp_err,   1'b0);
    chk("rst_ready", req_ready, '0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    started   = 1'b1;

    // Single AND
    op_s[0] = 3'd0;
    a_s[0]  = 32'hF0F0_1234;
    b_s[0]  = 32'h0FF0_FFFF;
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_data",  rsp_data,  32'h00F0_1234);
    chk("single_id",    rsp_id,    '0);
    chk("single_err",   rsp_err,   1'b0);

    // Remaining opcodes, including an illegal one
    a_s[0] = 32'hAAAA_5555;
    b_s[0] = 32'h0F0F_F0F0;
    for (int j = 0; j < 5; j++) begin
      op_s[0] = cov_op[j];
      step(2'b01, 1'b1);
      step(2'b00, 1'b1);
      chk("cov_data", rsp_data, cov_data[j]);
      chk("cov_err",  rsp_err,  cov_err[j]);
    end

    // Fill the slot and hold it, then reset mid-stream
    rand_ops();
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    chk("pre_midrst_valid", rsp_valid, 1'b1);
    mid_reset();

    // Round robin from a fresh pointer: ids alternate starting at 0
    for (int j = 0; j < 7; j++) begin
      rand_ops();
      step(2'b11, 1'b1);
      if (j > 0) begin
        chk("rr_valid", rsp_valid, 1'b1);
        chk("rr_id",    rsp_id,    64'((j - 1) % 2));
      end
    end

    // Backpressure for three cycles, then drain and refill together
    for (int j = 0; j < 3; j++) begin
      rand_ops();
      step(2'b11, 1'b0);
    end
    step(2'b11, 1'b1);

    // Drop-out: requester 1 is valid in a single cycle only
    step(2'b01, 1'b1);
    step(2'b01, 1'b1);
    step(2'b11, 1'b1);
    step(2'b01, 1'b1);
    step(2'b01, 1'b1);

    // Randomised traffic
    for (int j = 0; j < 400; j++) begin
      rand_ops();
      step(NREQ'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Drain, then confirm every expected response was seen
    for (int j = 0; j < 4; j++) step('0, 1'b1);
    @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
